hazard_forward_ctrl: RTL and testbench

//  Hazard/forwarding controller for the 5-stage pipeline. Sits beside the ID/EXE register and sequences it.

---
 rtl/hazard_forward_ctrl.sv | 135 +++++++++++++
 tb/tb_hazard_forward_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_ctrl.sv
// rtl/hazard_forward_ctrl.sv - load-use stall, memory-wait freeze and operand forwarding control
module hazard_forward_ctrl #(
  parameter int REG_AW = 5,
  parameter int FWD_W  = 2
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_wreg,
  input  logic              id_m2reg,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              dmem_ready,
  output logic              wpcir,
  output logic              bubble,
  output logic              freeze,
  output logic [FWD_W-1:0]  fwda,
  output logic [FWD_W-1:0]  fwdb,
  output logic [15:0]       stall_cnt
);

  typedef enum logic {RUN = 1'b0, MEMWAIT = 1'b1} state_t;

  state_t            state_q, state_d;
  logic              e_wreg_q, e_wreg_d;
  logic              e_m2reg_q, e_m2reg_d;
  logic [REG_AW-1:0] e_dest_q, e_dest_d;
  logic              m_wreg_q, m_wreg_d;
  logic              m_m2reg_q, m_m2reg_d;
  logic [REG_AW-1:0] m_dest_q, m_dest_d;
  logic [15:0]       stall_cnt_q, stall_cnt_d;

  logic match_e_rs, match_e_rt, match_m_rs, match_m_rt;
  logic loaduse, memwait;

  // Register 0 is hardwired to zero, so it never produces a hazard.
  assign match_e_rs = e_wreg_q && (e_dest_q == id_rs) && (id_rs != '0);
  assign match_e_rt = e_wreg_q && (e_dest_q == id_rt) && (id_rt != '0);
  assign match_m_rs = m_wreg_q && (m_dest_q == id_rs) && (id_rs != '0);
  assign match_m_rt = m_wreg_q && (m_dest_q == id_rt) && (id_rt != '0);

  assign loaduse = e_m2reg_q && ((id_use_rs && match_e_rs) || (id_use_rt && match_e_rt));
  assign memwait = m_m2reg_q && m_wreg_q && !dmem_ready;

  function automatic logic [FWD_W-1:0] fwd_sel(input logic use_r, input logic hit_e,
                                              input logic hit_m);
    logic [FWD_W-1:0] sel;
    sel = FWD_W'(2'b00);
    if (use_r) begin
      if (hit_e) begin
        if (!e_m2reg_q) sel = FWD_W'(2'b01);
      end else if (hit_m) begin
        sel = m_m2reg_q ? FWD_W'(2'b11) : FWD_W'(2'b10);
      end
    end
    return sel;
  endfunction

  assign fwda      = fwd_sel(id_use_rs, match_e_rs, match_m_rs);
  assign fwdb      = fwd_sel(id_use_rt, match_e_rt, match_m_rt);
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    state_d     = state_q;
    freeze      = 1'b0;
    bubble      = 1'b0;
    wpcir       = 1'b1;
    e_wreg_d    = e_wreg_q;
    e_m2reg_d   = e_m2reg_q;
    e_dest_d    = e_dest_q;
    m_wreg_d    = m_wreg_q;
    m_m2reg_d   = m_m2reg_q;
    m_dest_d    = m_dest_q;
    stall_cnt_d = stall_cnt_q;

    case (state_q)
      RUN: begin
        freeze = memwait;
        if (memwait) state_d = MEMWAIT;
      end
      MEMWAIT: begin
        freeze = !dmem_ready;
        if (dmem_ready) state_d = RUN;
      end
      default: state_d = RUN;
    endcase

    if (freeze) begin
      wpcir = 1'b0;
    end else if (loaduse) begin
      wpcir     = 1'b0;
      bubble    = 1'b1;
      e_wreg_d  = 1'b0;
      e_m2reg_d = 1'b0;
      e_dest_d  = '0;
      m_wreg_d  = e_wreg_q;
      m_m2reg_d = e_m2reg_q;
      m_dest_d  = e_dest_q;
    end else begin
      e_wreg_d  = id_wreg;
      e_m2reg_d = id_m2reg;
      e_dest_d  = id_dest;
      m_wreg_d  = e_wreg_q;
      m_m2reg_d = e_m2reg_q;
      m_dest_d  = e_dest_q;
    end

    if ((bubble || freeze) && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= RUN;
      e_wreg_q    <= 1'b0;
      e_m2reg_q   <= 1'b0;
      e_dest_q    <= '0;
      m_wreg_q    <= 1'b0;
      m_m2reg_q   <= 1'b0;
      m_dest_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      e_wreg_q    <= e_wreg_d;
      e_m2reg_q   <= e_m2reg_d;
      e_dest_q    <= e_dest_d;
      m_wreg_q    <= m_wreg_d;
      m_m2reg_q   <= m_m2reg_d;
      m_dest_q    <= m_dest_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// tb/tb_hazard_forward_ctrl.sv - self-checking bench for hazard_forward_ctrl
module tb_hazard_forward_ctrl;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, id_dest = '0;
  logic       id_use_rs = 1'b0, id_use_rt = 1'b0, id_wreg = 1'b0, id_m2reg = 1'b0;
  logic       dmem_ready = 1'b1;
  logic       wpcir, bubble, freeze;
  logic [1:0] fwda, fwdb;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  hazard_forward_ctrl #(.REG_AW(5), .FWD_W(2)) dut (
    .clock(clock), .resetn(resetn),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_wreg(id_wreg), .id_m2reg(id_m2reg), .id_dest(id_dest), .dmem_ready(dmem_ready),
    .wpcir(wpcir), .bubble(bubble), .freeze(freeze), .fwda(fwda), .fwdb(fwdb),
    .stall_cnt(stall_cnt)
  );

  always #5 clock = ~clock;

  // Architectural model: which instruction occupies EXE and MEM, and how many stall cycles so far.
  typedef struct {
    bit wreg;
    bit m2reg;
    int dest;
  } stage_t;

  stage_t ex, mem;
  int     cnt_m;

  function automatic bit hit(stage_t s, int r);
    return s.wreg && s.dest == r && r != 0;
  endfunction

  function automatic bit m_freeze();
    return mem.wreg && mem.m2reg && !dmem_ready;
  endfunction

  function automatic bit m_loaduse();
    return ex.m2reg && ((id_use_rs && hit(ex, int'(id_rs))) || (id_use_rt && hit(ex, int'(id_rt))));
  endfunction

  // Returns -1 where the select is don't-care (EXE load hit, covered by the stall).
  function automatic int m_fwd(bit use_r, int r);
    if (!use_r) return 0;
    if (hit(ex, r)) return ex.m2reg ? -1 : 1;
    if (hit(mem, r)) return mem.m2reg ? 3 : 2;
    return 0;
  endfunction

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ex = '{0, 0, 0};
      mem = '{0, 0, 0};
      cnt_m = 0;
    end else if (m_freeze()) begin
      cnt_m = (cnt_m < 65535) ? cnt_m + 1 : 65535;
    end else if (m_loaduse()) begin
      cnt_m = (cnt_m < 65535) ? cnt_m + 1 : 65535;
      mem = ex;
      ex = '{0, 0, 0};
    end else begin
      mem = ex;
      ex = '{id_wreg, id_m2reg, int'(id_dest)};
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    bit fz, lu;
    int fa, fb;
    fz = m_freeze();
    lu = m_loaduse();
    fa = m_fwd(id_use_rs, int'(id_rs));
    fb = m_fwd(id_use_rt, int'(id_rt));
    chk("model_freeze", int'(freeze), int'(fz));
    chk("model_bubble", int'(bubble), int'(!fz && lu));
    chk("model_wpcir", int'(wpcir), int'(!fz && !lu));
    chk("model_stall_cnt", int'(stall_cnt), cnt_m);
    if (fa >= 0) chk("model_fwda", int'(fwda), fa);
    if (fb >= 0) chk("model_fwdb", int'(fwdb), fb);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_id(input int rs, input int rt, input bit urs, input bit urt,
                        input bit wr, input bit ld, input int dest);
    id_rs = 5'(rs); id_rt = 5'(rt); id_use_rs = urs; id_use_rt = urt;
    id_wreg = wr; id_m2reg = ld; id_dest = 5'(dest);
  endtask

  task automatic outs(input string name, input int wp, input int bb, input int fz,
                      input int fa, input int fb);
    #1;
    chk({name, "_wpcir"}, int'(wpcir), wp);
    chk({name, "_bubble"}, int'(bubble), bb);
    chk({name, "_freeze"}, int'(freeze), fz);
    if (fa >= 0) chk({name, "_fwda"}, int'(fwda), fa);
    if (fb >= 0) chk({name, "_fwdb"}, int'(fwdb), fb);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0);
    dmem_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    outs("reset", 1, 0, 0, 0, 0);
    chk("reset_cnt", int'(stall_cnt), 0);
    resetn = 1'b1;
    #1;
  endtask

  initial begin
    do_reset();

    // Test 1: ALU result forwarded from EXE.
    set_id(1, 2, 1, 1, 1, 0, 3);
    tick();
    set_id(3, 1, 1, 1, 1, 0, 4);
    outs("t1_sub", 1, 0, 0, 1, 0);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0);
    repeat (2) tick();

    // Test 2: load-use stall then load data forwarded from MEM.
    do_reset();
    set_id(1, 0, 1, 0, 1, 1, 5);
    tick();
    set_id(5, 5, 1, 1, 1, 0, 6);
    outs("t2_stall", 0, 1, 0, -1, -1);
    tick();
    outs("t2_after", 1, 0, 0, 3, 3);
    chk("t2_cnt", int'(stall_cnt), 1);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0);
    repeat (2) tick();

    // Test 3: MEM load waits three cycles on data memory.
    do_reset();
    set_id(1, 0, 1, 0, 1, 1, 5);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0);
    tick();
    set_id(5, 0, 1, 0, 1, 0, 6);
    dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      outs("t3_freeze", 0, 0, 1, 3, 0);
      tick();
    end
    dmem_ready = 1'b1;
    outs("t3_release", 1, 0, 0, 3, 0);
    chk("t3_cnt", int'(stall_cnt), 3);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0);
    repeat (2) tick();

    // Test 4: r0 never matches; EXE wins over MEM.
    do_reset();
    set_id(0, 0, 0, 0, 1, 1, 0);
    tick();
    set_id(0, 0, 1, 1, 0, 0, 0);
    outs("t4_r0", 1, 0, 0, 0, 0);
    set_id(0, 0, 0, 0, 1, 0, 7);
    tick();
    tick();
    set_id(7, 7, 1, 1, 0, 0, 0);
    outs("t4_r7", 1, 0, 0, 1, 1);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0);
    repeat (2) tick();

    // Test 5: reset during a freeze and during a load-use stall.
    do_reset();
    set_id(1, 0, 1, 0, 1, 1, 5);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0);
    tick();
    set_id(5, 0, 1, 0, 0, 0, 0);
    dmem_ready = 1'b0;
    tick();
    outs("t5_frozen", 0, 0, 1, 3, 0);
    resetn = 1'b0;
    outs("t5_in_reset", 1, 0, 0, 0, 0);
    chk("t5_cnt", int'(stall_cnt), 0);
    tick();
    resetn = 1'b1;
    outs("t5_released", 1, 0, 0, 0, 0);
    tick();
    outs("t5_run", 1, 0, 0, 0, 0);
    dmem_ready = 1'b1;
    set_id(1, 0, 1, 0, 1, 1, 5);
    tick();
    set_id(5, 0, 1, 0, 0, 0, 0);
    outs("t5_stall", 0, 1, 0, -1, -1);
    resetn = 1'b0;
    outs("t5_stall_reset", 1, 0, 0, 0, 0);
    tick();
    resetn = 1'b1;
    tick();
    outs("t5_no_bubble", 1, 0, 0, 0, 0);
    set_id(0, 0, 0, 0, 0, 0, 0);

    // Test 6: stall counter saturation.
    do_reset();
    set_id(1, 0, 1, 0, 1, 1, 5);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0);
    tick();
    dmem_ready = 1'b0;
    repeat (70000) tick();
    chk("t6_saturate", int'(stall_cnt), 65535);
    dmem_ready = 1'b1;
    repeat (2) tick();
    chk("t6_hold", int'(stall_cnt), 65535);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
